uop_sequencer: RTL and testbench
================================

UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 SHALL have parameter UOP_W, default 20, micro-op word width.
REQ-002 SHALL have parameter SLOTS, default 2, instruction buffer depth; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port a_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port hold, input, 1 bit: pipeline freeze.
REQ-006 SHALL have port flush, input, 1 bit: discard all buffered and in-flight micro-ops (redirect).
REQ-007 SHALL have port feed_req, output, 1 bit: sequencer can accept one decoded instruction.
REQ-008 SHALL have port feed_ack, input, 1 bit: decode has issued an instruction this cycle.
REQ-009 SHALL have ports uop_0, uop_1, uop_2, inputs, UOP_W each: decoded micro-ops.
REQ-010 SHALL have port uop_count, input, 2 bits: extra micro-ops beyond uop_0.
REQ-011 SHALL have port uop_out, output, UOP_W: micro-op presented to execute.
REQ-012 SHALL have port uop_valid, output, 1 bit: uop_out is valid.
REQ-013 SHALL have port uop_ready, input, 1 bit: execute accepts uop_out.
REQ-014 SHALL have port uop_last, output, 1 bit: uop_out is the final micro-op (uop_0) of its instruction.
REQ-015 SHALL have port empty, output, 1 bit: no instruction buffered.

Function
REQ-016 SHALL buffer up to SLOTS instructions in a circular queue; each slot holds uop_0, uop_1, uop_2 and a 2-bit count.
REQ-017 SHALL drive feed_req = (occupancy < SLOTS) & ~hold & ~flush, combinationally.
REQ-018 SHALL write the tail slot when feed_ack & feed_req; feed_ack while feed_req is low SHALL be ignored.
REQ-019 SHALL store uop_count 2'b11 as 2'b10 (reserved encoding).
REQ-020 SHALL expand the head instruction in the order uop_2, uop_1, uop_0 for count 2; uop_1, uop_0 for count 1; uop_0 only for count 0.
REQ-021 SHALL track the head with a step register loaded with the slot count when that slot becomes head; uop_out selects uop_2, uop_1 or uop_0 for step 2, 1 or 0.
REQ-022 SHALL drive uop_valid = ~empty & ~hold, and uop_last = uop_valid & (step == 0).
REQ-023 SHALL transfer a micro-op when uop_valid & uop_ready: step > 0 decrements step; step == 0 pops the head and loads step from the next slot's count.
REQ-024 SHALL present the first micro-op one cycle after the accepting edge (no combinational bypass).
REQ-025 SHALL allow a push and a pop on the same edge; occupancy is then unchanged.
REQ-026 SHALL wrap read and write pointers modulo SLOTS.
REQ-027 SHALL, on flush, clear occupancy, pointers and step on the next edge; flush overrides a same-cycle pop or push.
REQ-028 SHALL, when hold is high and flush is low, freeze all state; uop_valid and feed_req are low.
REQ-029 SHALL keep uop_out stable while uop_valid is high and uop_ready is low.

Reset
REQ-030 SHALL, on a_rst high, immediately clear occupancy, pointers and step. Outputs: feed_req 0 while reset is asserted, uop_valid 0, uop_last 0, empty 1, uop_out all-zero.
REQ-031 SHALL discard any partially expanded instruction on reset mid-operation.
REQ-032 SHALL not clear slot payload storage on reset; only control state is reset.

Structure
REQ-033 SHALL take UOP_W, the uop_count encodings and the reserved-count rule from the shared core package used by decode_unit.
REQ-034 SHALL be built as one sub-module, uop_slot_queue (storage, pointers, occupancy), plus expansion and step logic in uop_sequencer.

Verification
REQ-035 SHALL verify count 2: ack with uop_2=0x00002, uop_1=0x00001, uop_0=0x00000, uop_ready=1 -> uop_out 2, 1, 0 on three consecutive cycles; uop_last only on the third.
REQ-036 SHALL verify back-pressure: two count-0 acks, uop_ready=0 -> feed_req drops after the second ack; releasing uop_ready delivers both in order.
REQ-037 SHALL verify concurrency: occupancy 1, final micro-op popped while a new ack arrives -> occupancy stays 1, feed_req stays 1.
REQ-038 SHALL verify flush: flush at step 1 of a count-2 instruction -> uop_valid 0 and empty 1 next cycle; a same-cycle feed_ack is dropped.
REQ-039 SHALL verify hold: hold for 3 cycles mid-expansion -> uop_valid 0, step frozen, expansion resumes at the same micro-op.
REQ-040 SHALL verify reset: a_rst pulse mid-expansion -> empty 1 and uop_valid 0 asynchronously; uop_count 2'b11 afterwards expands as 3 micro-ops.

Source files
------------

// File: rtl/uop_sequencer_pkg.sv
// Shared core definitions for the decode/sequencer boundary: micro-op width,
// micro-op count encodings and the reserved-count rule.
package uop_sequencer_pkg;

  localparam int UOP_W_DEF = 20;

  // uop_count = number of extra micro-ops beyond uop_0
  typedef enum logic [1:0] {
    UC_ONE   = 2'b00,
    UC_TWO   = 2'b01,
    UC_THREE = 2'b10,
    UC_RSVD  = 2'b11
  } uop_cnt_e;

  // The reserved encoding is treated as the largest legal count
  function automatic logic [1:0] norm_count(input logic [1:0] c);
    return (c == UC_RSVD) ? UC_THREE : c;
  endfunction

endpackage

// File: rtl/uop_slot_queue.sv
// Circular instruction buffer: payload storage, read/write pointers, occupancy.
// Push/pop arrive already qualified by hold; flush clears control state.
module uop_slot_queue
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF,
  parameter int SLOTS = 2,
  localparam int PW = $clog2(SLOTS),
  localparam int OW = $clog2(SLOTS + 1)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [2:0][UOP_W-1:0] wr_uops,
  input  logic [1:0]            wr_cnt,
  output logic [OW-1:0]         occ,
  output logic                  empty,
  output logic                  full,
  output logic [2:0][UOP_W-1:0] hd_uops,
  output logic [1:0]            hd_cnt,
  output logic [1:0]            nx_cnt
);

  logic [SLOTS-1:0][2:0][UOP_W-1:0] mem;
  logic [SLOTS-1:0][1:0]            cnt_mem;
  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    rd_ptr;
  logic [PW-1:0]                    nx_ptr;

  // Payload is never reset; only control state decides what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= wr_uops;
      cnt_mem[wr_ptr] <= wr_cnt;
    end
  end

  // Pointers wrap naturally because SLOTS is a power of two
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign nx_ptr  = rd_ptr + 1'b1;
  assign empty   = (occ == '0);
  assign full    = (occ == OW'(SLOTS));
  assign hd_uops = mem[rd_ptr];
  assign hd_cnt  = cnt_mem[rd_ptr];
  assign nx_cnt  = cnt_mem[nx_ptr];

endmodule

// File: rtl/uop_sequencer.sv
// Micro-op sequencer: buffers decoded instructions and expands each head
// instruction into uop_2..uop_0 (highest first), one per accepted transfer.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF,
  parameter int SLOTS = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             hold,
  input  logic             flush,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [UOP_W-1:0] uop_0,
  input  logic [UOP_W-1:0] uop_1,
  input  logic [UOP_W-1:0] uop_2,
  input  logic [1:0]       uop_count,
  output logic [UOP_W-1:0] uop_out,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic             uop_last,
  output logic             empty
);

  localparam int OW = $clog2(SLOTS + 1);

  logic [OW-1:0]         occ;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  xfer;
  logic [1:0]            step;
  logic [1:0]            wr_cnt;
  logic [1:0]            hd_cnt;
  logic [1:0]            nx_cnt;
  logic [2:0][UOP_W-1:0] hd_uops;
  logic [2:0][UOP_W-1:0] wr_uops;

  assign feed_req  = ~full & ~hold & ~flush & ~a_rst;
  assign push      = feed_ack & feed_req;
  assign wr_cnt    = norm_count(uop_count);
  assign wr_uops   = {uop_2, uop_1, uop_0};
  assign uop_valid = ~empty & ~hold;
  assign uop_last  = uop_valid & (step == 2'd0);
  assign xfer      = uop_valid & uop_ready;
  assign pop       = xfer & (step == 2'd0) & ~flush;

  uop_slot_queue #(.UOP_W(UOP_W), .SLOTS(SLOTS)) u_q (
    .clk     (clk),
    .a_rst   (a_rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_uops (wr_uops),
    .wr_cnt  (wr_cnt),
    .occ     (occ),
    .empty   (empty),
    .full    (full),
    .hd_uops (hd_uops),
    .hd_cnt  (hd_cnt),
    .nx_cnt  (nx_cnt)
  );

  // Step counts down within the head; reloads with whichever slot becomes head
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      step <= 2'd0;
    end else if (flush) begin
      step <= 2'd0;
    end else if (xfer && step != 2'd0) begin
      step <= step - 2'd1;
    end else if (pop) begin
      if (occ > OW'(1))  step <= nx_cnt;
      else if (push)     step <= wr_cnt;
      else               step <= 2'd0;
    end else if (push && empty) begin
      step <= wr_cnt;
    end
  end

  // Select the current micro-op; all-zero whenever nothing is buffered
  always_comb begin
    uop_out = '0;
    if (!empty) begin
      case (step)
        2'd2:    uop_out = hd_uops[2];
        2'd1:    uop_out = hd_uops[1];
        default: uop_out = hd_uops[0];
      endcase
    end
  end

  // hd_cnt is only meaningful for debug views of the head slot
  logic unused_hd_cnt;
  assign unused_hd_cnt = ^hd_cnt;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: a vector table for steady-state behaviour
// plus hand sequences for flush and asynchronous reset mid-expansion.
module tb_uop_sequencer;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         a_rst;
  logic         hold, flush, feed_ack, uop_ready;
  logic [W-1:0] uop_0, uop_1, uop_2;
  logic [1:0]   uop_count;
  logic         feed_req, uop_valid, uop_last, empty;
  logic [W-1:0] uop_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uop_sequencer #(.UOP_W(W), .SLOTS(2)) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .hold      (hold),
    .flush     (flush),
    .feed_req  (feed_req),
    .feed_ack  (feed_ack),
    .uop_0     (uop_0),
    .uop_1     (uop_1),
    .uop_2     (uop_2),
    .uop_count (uop_count),
    .uop_out   (uop_out),
    .uop_valid (uop_valid),
    .uop_ready (uop_ready),
    .uop_last  (uop_last),
    .empty     (empty)
  );

  typedef struct {
    logic         hold, flush, ack;
    logic [1:0]   cnt;
    logic [W-1:0] u2, u1, u0;
    logic         rdy;
    logic         efr, evl, els, eem;
    logic [W-1:0] eout;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(input logic h, f, a, input logic [1:0] c,
                              input logic [W-1:0] v2, v1, v0, input logic r,
                              input logic fr, vl, ls, em, input logic [W-1:0] o);
    vec_t v;
    v.hold = h; v.flush = f; v.ack = a; v.cnt = c;
    v.u2 = v2; v.u1 = v1; v.u0 = v0; v.rdy = r;
    v.efr = fr; v.evl = vl; v.els = ls; v.eem = em; v.eout = o;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic fr, vl, ls, em,
                         input logic [W-1:0] o);
    chk({tag, ".feed_req"},  idx, 32'(feed_req),  32'(fr));
    chk({tag, ".uop_valid"}, idx, 32'(uop_valid), 32'(vl));
    chk({tag, ".uop_last"},  idx, 32'(uop_last),  32'(ls));
    chk({tag, ".empty"},     idx, 32'(empty),     32'(em));
    chk({tag, ".uop_out"},   idx, 32'(uop_out),   32'(o));
  endtask

  task automatic drive(input logic h, f, a, input logic [1:0] c,
                       input logic [W-1:0] v2, v1, v0, input logic r);
    hold = h; flush = f; feed_ack = a; uop_count = c;
    uop_2 = v2; uop_1 = v1; uop_0 = v0; uop_ready = r;
  endtask

  initial begin
    //             h  f  a  c  u2     u1     u0     r   fr vl ls em out
    tv[0]  = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 0, 0, 1, 0);
    tv[1]  = mk(0, 0, 1, 2, 20'h2, 20'h1, 20'h0, 1,  1, 0, 0, 1, 0);
    tv[2]  = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 0, 0, 20'h2);
    tv[3]  = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 0, 0, 20'h1);
    tv[4]  = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 1, 0, 20'h0);
    tv[5]  = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 0, 0, 1, 0);
    // back-pressure: two single-uop instructions, execute stalled
    tv[6]  = mk(0, 0, 1, 0, 0,     0,     20'hA, 0,  1, 0, 0, 1, 0);
    tv[7]  = mk(0, 0, 1, 0, 0,     0,     20'hB, 0,  1, 1, 1, 0, 20'hA);
    tv[8]  = mk(0, 0, 1, 0, 0,     0,     20'hFF,0,  0, 1, 1, 0, 20'hA);
    tv[9]  = mk(0, 0, 0, 0, 0,     0,     0,     1,  0, 1, 1, 0, 20'hA);
    tv[10] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 1, 0, 20'hB);
    tv[11] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 0, 0, 1, 0);
    // pop of final uop concurrent with a new push
    tv[12] = mk(0, 0, 1, 0, 0,     0,     20'h11,0,  1, 0, 0, 1, 0);
    tv[13] = mk(0, 0, 1, 1, 0,     20'h22,20'h21,1,  1, 1, 1, 0, 20'h11);
    tv[14] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 0, 0, 20'h22);
    tv[15] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 1, 0, 20'h21);
    // hold for three cycles mid-expansion; ack during hold is ignored
    tv[16] = mk(0, 0, 1, 2, 20'h32,20'h31,20'h30,1,  1, 0, 0, 1, 0);
    tv[17] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 0, 0, 20'h32);
    tv[18] = mk(1, 0, 1, 0, 0,     0,     20'hEE,1,  0, 0, 0, 0, 20'h31);
    tv[19] = mk(1, 0, 0, 0, 0,     0,     0,     1,  0, 0, 0, 0, 20'h31);
    tv[20] = mk(1, 0, 0, 0, 0,     0,     0,     1,  0, 0, 0, 0, 20'h31);
    tv[21] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 0, 0, 20'h31);
    tv[22] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 1, 1, 0, 20'h30);
    tv[23] = mk(0, 0, 0, 0, 0,     0,     0,     1,  1, 0, 0, 1, 0);

    a_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all("rst", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tv[i].hold, tv[i].flush, tv[i].ack, tv[i].cnt,
            tv[i].u2, tv[i].u1, tv[i].u0, tv[i].rdy);
      #1;
      chk_all("vec", i, tv[i].efr, tv[i].evl, tv[i].els, tv[i].eem, tv[i].eout);
    end

    // flush at step 1 of a three-uop instruction, with a same-cycle ack
    @(negedge clk);
    drive(0, 0, 1, 2, 20'h42, 20'h41, 20'h40, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk_all("fl", 0, 1, 1, 0, 0, 20'h42);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0, 20'h55, 1);
    #1 chk("fl.feed_req_flush", 1, 32'(feed_req), 32'd0);
    chk("fl.uop_out_step1", 1, 32'(uop_out), 32'h41);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk_all("fl", 2, 1, 0, 0, 1, 0);
    @(negedge clk);
    #1 chk_all("fl", 3, 1, 0, 0, 1, 0);

    // asynchronous reset mid-expansion, then reserved count expands as three
    @(negedge clk);
    drive(0, 0, 1, 2, 20'h62, 20'h61, 20'h60, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk_all("ar", 0, 1, 1, 0, 0, 20'h62);
    @(posedge clk);
    #2 a_rst = 1'b1;
    #1 chk_all("ar", 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    a_rst = 1'b0;
    #1 chk_all("ar", 2, 1, 0, 0, 1, 0);
    drive(0, 0, 1, 3, 20'h73, 20'h72, 20'h71, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk_all("ar", 3, 1, 1, 0, 0, 20'h73);
    @(negedge clk);
    #1 chk_all("ar", 4, 1, 1, 0, 0, 20'h72);
    @(negedge clk);
    #1 chk_all("ar", 5, 1, 1, 1, 0, 20'h71);
    @(negedge clk);
    #1 chk_all("ar", 6, 1, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
